// File: rtl/div_iter_if.sv
// Handshake bundle between the EX stage and the iterative divider.
// The EX side drives operands/start/annul; the divider returns result, ready and stall request.
interface div_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               stallreq_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle.
// Result is {remainder, quotient}; stallreq_o holds the pipeline until ready_o rises.
module div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  div_iter_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StByZero, StOn, StEnd} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;   // dividend bits shift out MSB-first, quotient bits shift in
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               neg_quot_q, neg_quot_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [WIDTH-1:0] op1_mag, op2_mag;
  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH-1:0] rem_step, dvd_step, quot_fix, rem_fix;

  // Most-negative operand negates to itself, which reads as 2^(WIDTH-1) unsigned.
  assign op1_mag = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i
                                                                : bus.opdata1_i;
  assign op2_mag = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i
                                                                : bus.opdata2_i;

  assign trial    = {rem_q, dvd_q[WIDTH-1]} - {1'b0, dvs_q};
  assign q_bit    = ~trial[WIDTH];
  assign rem_step = q_bit ? trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
  assign dvd_step = {dvd_q[WIDTH-2:0], q_bit};
  assign quot_fix = neg_quot_q ? -dvd_step : dvd_step;
  assign rem_fix  = neg_rem_q ? -rem_step : rem_step;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;

    if (bus.annul_i) begin
      state_d  = StIdle;
      cnt_d    = '0;
      ready_d  = 1'b0;
      result_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start_i) begin
            dvd_d      = op1_mag;
            dvs_d      = op2_mag;
            rem_d      = '0;
            cnt_d      = '0;
            neg_quot_d = bus.signed_div_i & (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
            neg_rem_d  = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
            state_d    = (bus.opdata2_i == '0) ? StByZero : StOn;
          end
        end
        StByZero: begin
          state_d  = StEnd;
          ready_d  = 1'b1;
          result_d = '0;
        end
        StOn: begin
          rem_d = rem_step;
          dvd_d = dvd_step;
          cnt_d = cnt_q + 1'b1;
          // Final bit: sign-fixed result goes straight into the output register.
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_d  = StEnd;
            ready_d  = 1'b1;
            result_d = {rem_fix, quot_fix};
          end
        end
        StEnd: begin
          if (!bus.start_i) begin
            state_d  = StIdle;
            ready_d  = 1'b0;
            result_d = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign bus.result_o   = result_q;
  assign bus.ready_o    = ready_q;
  assign bus.stallreq_o = bus.start_i & ~ready_q & ~bus.annul_i & ~rst;
endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: latency, signed/unsigned results, divide-by-zero, annul, reset
// and back-to-back issue, each against hand-computed values.
module tb_div_iter;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  div_iter_if #(.WIDTH(32)) div_bus ();

  div_iter #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (div_bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives one divide from cycle 0 and waits (bounded) for ready_o. Operands are scrambled
  // after acceptance. stall_ok clears if stallreq_o is not high before ready / low at ready.
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [63:0] res, output logic stall_ok);
    lat      = -1;
    res      = '0;
    stall_ok = 1'b1;
    div_bus.signed_div_i = sgn;
    div_bus.opdata1_i    = a;
    div_bus.opdata2_i    = b;
    div_bus.start_i      = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      if (div_bus.ready_o === 1'b1) begin
        lat = c;
        res = div_bus.result_o;
        if (div_bus.stallreq_o !== 1'b0) stall_ok = 1'b0;
        break;
      end
      if (div_bus.stallreq_o !== 1'b1) stall_ok = 1'b0;
      @(posedge clk);
      #1;
      div_bus.opdata1_i = ~a;
      div_bus.opdata2_i = 32'h0;
    end
  endtask

  task automatic end_div();
    @(posedge clk);
    #1;
    div_bus.start_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    div_bus.start_i = 1'b1;
    div_bus.opdata1_i = 32'd9;
    div_bus.opdata2_i = 32'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (div_bus.ready_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_ready: got %b expected 0", div_bus.ready_o);
    end
    vectors++;
    if (div_bus.result_o !== 64'h0) begin
      miscompares++; $display("FAIL reset_result: got %h expected 0", div_bus.result_o);
    end
    vectors++;
    if (div_bus.stallreq_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_stall: got %b expected 0", div_bus.stallreq_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    div_bus.start_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_unsigned();
    int lat; logic [63:0] res; logic ok;
    do_div(1'b0, 32'd100, 32'd7, lat, res, ok);
    vectors++;
    if (lat !== 33) begin miscompares++; $display("FAIL udiv_latency: got %0d expected 33", lat); end
    vectors++;
    if (res !== 64'h00000002_0000000E) begin
      miscompares++; $display("FAIL udiv_result: got %h expected 000000020000000e", res);
    end
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL udiv_stall: got %b expected 1", ok); end
    end_div();
    vectors++;
    if (div_bus.ready_o !== 1'b0 || div_bus.result_o !== 64'h0) begin
      miscompares++;
      $display("FAIL udiv_clear: got ready=%b result=%h expected 0/0",
               div_bus.ready_o, div_bus.result_o);
    end
  endtask

  task automatic test_signed();
    int lat; logic [63:0] res; logic ok;
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, lat, res, ok);
    vectors++;
    if (res !== 64'hFFFFFFFF_FFFFFFFD || lat !== 33) begin
      miscompares++;
      $display("FAIL sdiv_neg7_2: got %h lat %0d expected fffffffffffffffd lat 33", res, lat);
    end
    end_div();
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, ok);
    vectors++;
    if (res !== 64'h00000000_80000000 || lat !== 33) begin
      miscompares++;
      $display("FAIL sdiv_overflow: got %h lat %0d expected 0000000080000000 lat 33", res, lat);
    end
    end_div();
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, lat, res, ok);
    vectors++;
    if (res !== 64'h00000001_FFFFFFFD) begin
      miscompares++; $display("FAIL sdiv_7_neg2: got %h expected 00000001fffffffd", res);
    end
    end_div();
  endtask

  task automatic test_div_by_zero();
    int lat; logic [63:0] res; logic ok;
    do_div(1'b0, 32'd5, 32'd0, lat, res, ok);
    vectors++;
    if (lat !== 2) begin miscompares++; $display("FAIL dbz_latency: got %0d expected 2", lat); end
    vectors++;
    if (res !== 64'h0) begin miscompares++; $display("FAIL dbz_result: got %h expected 0", res); end
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL dbz_stall: got %b expected 1", ok); end
    end_div();
  endtask

  task automatic test_annul();
    int lat; logic [63:0] res; logic ok;
    div_bus.signed_div_i = 1'b0;
    div_bus.opdata1_i    = 32'd1000;
    div_bus.opdata2_i    = 32'd3;
    div_bus.start_i      = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    div_bus.annul_i = 1'b1;
    div_bus.start_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (div_bus.stallreq_o !== 1'b0) begin
      miscompares++; $display("FAIL annul_stall: got %b expected 0", div_bus.stallreq_o);
    end
    @(posedge clk);
    #1;
    div_bus.annul_i = 1'b0;
    vectors++;
    if (div_bus.ready_o !== 1'b0 || div_bus.result_o !== 64'h0) begin
      miscompares++;
      $display("FAIL annul_clear: got ready=%b result=%h expected 0/0",
               div_bus.ready_o, div_bus.result_o);
    end
    repeat (30) @(posedge clk);
    #1;
    vectors++;
    if (div_bus.ready_o !== 1'b0) begin
      miscompares++; $display("FAIL annul_no_escape: got %b expected 0", div_bus.ready_o);
    end
    do_div(1'b0, 32'hFFFF_FFFF, 32'd3, lat, res, ok);
    vectors++;
    if (res !== 64'h00000000_55555555 || lat !== 33) begin
      miscompares++;
      $display("FAIL annul_next: got %h lat %0d expected 0000000055555555 lat 33", res, lat);
    end
    end_div();
  endtask

  task automatic test_rst_mid();
    int lat; logic [63:0] res; logic ok;
    div_bus.signed_div_i = 1'b0;
    div_bus.opdata1_i    = 32'd500;
    div_bus.opdata2_i    = 32'd9;
    div_bus.start_i      = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    div_bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    vectors++;
    if (div_bus.ready_o !== 1'b0 || div_bus.result_o !== 64'h0 || div_bus.stallreq_o !== 1'b0)
    begin
      miscompares++;
      $display("FAIL rst_mid_clear: got ready=%b result=%h stall=%b expected 0/0/0",
               div_bus.ready_o, div_bus.result_o, div_bus.stallreq_o);
    end
    @(posedge clk);
    #1;
    do_div(1'b0, 32'd12345, 32'd100, lat, res, ok);
    vectors++;
    if (res !== 64'h0000002D_0000007B || lat !== 33) begin
      miscompares++;
      $display("FAIL rst_mid_next: got %h lat %0d expected 0000002d0000007b lat 33", res, lat);
    end
    end_div();
  endtask

  task automatic test_back_to_back();
    int lat; logic [63:0] res; logic ok;
    do_div(1'b0, 32'd1000, 32'd7, lat, res, ok);
    vectors++;
    if (res !== 64'h00000006_0000008E || lat !== 33) begin
      miscompares++;
      $display("FAIL b2b_first: got %h lat %0d expected 000000060000008e lat 33", res, lat);
    end
    @(posedge clk);
    #1;
    div_bus.start_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (div_bus.ready_o !== 1'b1 || div_bus.result_o !== 64'h00000006_0000008E) begin
      miscompares++;
      $display("FAIL b2b_hold: got ready=%b result=%h expected 1/000000060000008e",
               div_bus.ready_o, div_bus.result_o);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (div_bus.ready_o !== 1'b0 || div_bus.result_o !== 64'h0) begin
      miscompares++;
      $display("FAIL b2b_idle: got ready=%b result=%h expected 0/0",
               div_bus.ready_o, div_bus.result_o);
    end
    do_div(1'b0, 32'hFFFF_FFFF, 32'h10, lat, res, ok);
    vectors++;
    if (res !== 64'h0000000F_0FFFFFFF || lat !== 33 || ok !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_second: got %h lat %0d stall_ok %b expected 0000000f0fffffff lat 33 1",
               res, lat, ok);
    end
    end_div();
  endtask

  initial begin
    vectors              = 0;
    miscompares          = 0;
    rst                  = 1'b1;
    div_bus.signed_div_i = 1'b0;
    div_bus.opdata1_i    = '0;
    div_bus.opdata2_i    = '0;
    div_bus.start_i      = 1'b0;
    div_bus.annul_i      = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_by_zero();
    test_annul();
    test_rst_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
